mc_state_sequencer: RTL and testbench
=====================================

Name: mc_state_sequencer

Overview:
- State register and next-state sequencer for the multicycle MIPS CPU.
- Drives the 3-bit `state` bus read by the control output-decode block.
- Decides IF/ID/EXE/MEM/WB progression from the IR opcode.
- Inserts wait cycles for instruction/data memory handshakes, latches halt, and keeps cycle/retired-instruction counters for the debug display.

Parameters:
- CNT_W, 32, width of cycle_cnt and instr_cnt (wrap modulo 2^CNT_W).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from ID onward.
- imem_ready  in  1  instruction memory has data; IF completes only when high.
- dmem_ready  in  1  data memory access done; MEM completes only when high.
- state  out  3  current state code.
- halted  out  1  sticky; halt instruction decoded.
- instr_retire  out  1  combinational; high in the final cycle of an instruction that advances.
- cycle_cnt  out  CNT_W  cycles since reset, frozen while halted.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- Clocking and reset:
  - One clock: CLK. Reset is asynchronous and active-high.
  - All state elements update on posedge CLK and clear asynchronously on posedge Reset.
- Reset values: state=IF(000), halted=0, cycle_cnt=0, instr_cnt=0. instr_retire is 0 during and immediately after reset because state is IF.
- State codes (fixed; the output decoder depends on them): IF=000, ID=001, aEXE=110, bEXE=101, cEXE=010, MEM=011, aWB=111, cWB=100.
- Opcodes: addi 000010, ori 010010, sll 011000, add 000000, sub 000001, move 100000, slt 100111, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, Or 010000, And 010001, jal 111010, halt 111111.
- Transitions:
  - IF: imem_ready=1 -> ID. Otherwise stay in IF (wait).
  - IF while halted=1: stay in IF unconditionally.
  - ID:
    - j/jr/jal -> IF, retire.
    - halt -> IF, set halted; does not retire.
    - beq -> bEXE.
    - sw/lw -> cEXE.
    - all other opcodes (including undefined) -> aEXE.
  - aEXE -> aWB. aWB -> IF, retire.
  - bEXE -> IF, retire.
  - cEXE -> MEM.
  - MEM:
    - dmem_ready=0 -> stay in MEM.
    - sw -> IF, retire.
    - lw -> cWB.
  - cWB -> IF, retire.
  - Unused codes: none exist, since all 8 codes are assigned.
- instr_retire: high exactly in the retiring cycles listed above; instr_cnt increments at that clock edge.
- Cycle counter:
  - cycle_cnt increments every clock while halted=0, including the cycle in which halt is decoded.
  - Frozen once halted=1.
- Counters wrap from all-ones to 0 with no flag.
- halted is cleared only by Reset.
- Reset mid-instruction (any state, any wait): immediate return to IF with counters cleared. No partial retire is counted.
- Wait states:
  - Ready inputs are sampled only in their own state (imem_ready in IF, dmem_ready in MEM).
  - Ready asserted in any other state has no effect.
- Latency without waits: j/jr/jal 2 cycles; beq 3; R/I-type ALU 4; sw 4; lw 5.

Decomposition:
- Shared package mc_ctrl_pkg holds the 3-bit state localparams and 6-bit opcode localparams.
- The output-decode block and this block both use that package, so the codes stay in one place.
- One combinational sub-module, mc_next_state (state, opcode, imem_ready, dmem_ready, halted -> next_state, retire, set_halt), keeps this block's register logic small.

Test Plan:
- Reset asserted mid-MEM -> state=000 immediately (asynchronously); after release, cycle_cnt counts 1,2,...; instr_cnt=0.
- add with both readies tied 1 -> state sequence 000,001,110,111,000; instr_retire high in the 111 cycle only; instr_cnt=1 after 4 cycles.
- lw with dmem_ready held low for 3 MEM cycles -> 000,001,010,011,011,011,011,100,000; retire only in 100; cycle_cnt=8 at return to IF.
- Instruction stream beq, then sw, then j -> bEXE(101) followed by IF; sw ends MEM->IF; j retires from ID; instr_cnt=3 after 3+4+2=9 cycles.
- imem_ready low for 2 cycles in IF -> state stays 000 for 3 cycles total; instr_cnt unchanged; cycle_cnt advances.
- halt opcode -> ID->IF, halted=1, state stuck at 000 for 100 cycles, cycle_cnt frozen at its value+1, instr_cnt unchanged; Reset clears halted.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared state and opcode codes for the multicycle MIPS control path.
// The output decoder relies on these exact state encodings.
package mc_ctrl_pkg;

    localparam logic [2:0] ST_IF   = 3'b000;
    localparam logic [2:0] ST_ID   = 3'b001;
    localparam logic [2:0] ST_AEXE = 3'b110;
    localparam logic [2:0] ST_BEXE = 3'b101;
    localparam logic [2:0] ST_CEXE = 3'b010;
    localparam logic [2:0] ST_MEM  = 3'b011;
    localparam logic [2:0] ST_AWB  = 3'b111;
    localparam logic [2:0] ST_CWB  = 3'b100;

    typedef enum logic [2:0] {
        S_IF   = ST_IF,
        S_ID   = ST_ID,
        S_AEXE = ST_AEXE,
        S_BEXE = ST_BEXE,
        S_CEXE = ST_CEXE,
        S_MEM  = ST_MEM,
        S_AWB  = ST_AWB,
        S_CWB  = ST_CWB
    } state_e;

    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SLT  = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/mc_next_state.sv
// Next-state, retire and halt-set decode for the multicycle sequencer.
// Purely combinational; the caller owns all registers.
module mc_next_state
    import mc_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       halted,
    output state_e     next_state,
    output logic       retire,
    output logic       set_halt
);

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        set_halt   = 1'b0;
        unique case (state)
            S_IF: begin
                if (!halted && imem_ready)
                    next_state = S_ID;
            end
            S_ID: begin
                unique case (opcode)
                    OP_J, OP_JR, OP_JAL: begin
                        next_state = S_IF;
                        retire     = 1'b1;
                    end
                    OP_HALT: begin
                        next_state = S_IF;
                        set_halt   = 1'b1;
                    end
                    OP_BEQ:       next_state = S_BEXE;
                    OP_SW, OP_LW: next_state = S_CEXE;
                    default:      next_state = S_AEXE;
                endcase
            end
            S_AEXE: next_state = S_AWB;
            S_BEXE: begin
                next_state = S_IF;
                retire     = 1'b1;
            end
            S_CEXE: next_state = S_MEM;
            S_MEM: begin
                // Only sw and lw reach MEM, so anything but lw ends here
                if (dmem_ready) begin
                    if (opcode == OP_LW) begin
                        next_state = S_CWB;
                    end else begin
                        next_state = S_IF;
                        retire     = 1'b1;
                    end
                end
            end
            S_AWB, S_CWB: begin
                next_state = S_IF;
                retire     = 1'b1;
            end
            default: next_state = S_IF;
        endcase
    end

endmodule

// File: rtl/mc_state_sequencer.sv
// State register, halt latch and debug counters for the multicycle CPU.
// Sequencing decisions come from mc_next_state.
module mc_state_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic             halted,
    output logic             instr_retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e cur;
    state_e nxt;
    logic   retire;
    logic   set_halt;

    mc_next_state u_next (
        .state      (cur),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .halted     (halted),
        .next_state (nxt),
        .retire     (retire),
        .set_halt   (set_halt)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cur       <= S_IF;
            halted    <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cur <= nxt;
            if (set_halt)
                halted <= 1'b1;
            // The halt-decode cycle still counts; freezing starts after
            if (!halted)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (retire)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

    assign state        = cur;
    assign instr_retire = retire;

endmodule

// File: tb/tb_mc_state_sequencer.sv
// Randomized bench for mc_state_sequencer against a per-instruction
// expected state trace built from opcode class and planned wait counts.
module tb_mc_state_sequencer;

    localparam int W = 5;

    localparam logic [2:0] C_IF   = 3'b000;
    localparam logic [2:0] C_ID   = 3'b001;
    localparam logic [2:0] C_AEXE = 3'b110;
    localparam logic [2:0] C_BEXE = 3'b101;
    localparam logic [2:0] C_CEXE = 3'b010;
    localparam logic [2:0] C_MEM  = 3'b011;
    localparam logic [2:0] C_AWB  = 3'b111;
    localparam logic [2:0] C_CWB  = 3'b100;

    localparam int K_JUMP = 0;
    localparam int K_HALT = 1;
    localparam int K_BEQ  = 2;
    localparam int K_SW   = 3;
    localparam int K_LW   = 4;
    localparam int K_ALU  = 5;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [5:0]   opcode;
    logic         imem_ready;
    logic         dmem_ready;
    logic [2:0]   state;
    logic         halted;
    logic         instr_retire;
    logic [W-1:0] cycle_cnt;
    logic [W-1:0] instr_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] m_cyc;
    logic [W-1:0] m_ins;
    logic         m_halt;

    logic [5:0] known_ops [15] = '{
        6'b000010, 6'b010010, 6'b011000, 6'b000000, 6'b000001,
        6'b100000, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
        6'b111000, 6'b111001, 6'b010000, 6'b010001, 6'b111010
    };

    mc_state_sequencer #(.CNT_W(W)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .opcode       (opcode),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .state        (state),
        .halted       (halted),
        .instr_retire (instr_retire),
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b111000, 6'b111001, 6'b111010: return K_JUMP;
            6'b111111:                       return K_HALT;
            6'b110100:                       return K_BEQ;
            6'b110000:                       return K_SW;
            6'b110001:                       return K_LW;
            default:                         return K_ALU;
        endcase
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        if ($urandom_range(0, 3) == 0) begin
            op = 6'($urandom);
            if (op == 6'b111111)
                op = 6'b000000;
        end else begin
            op = known_ops[$urandom_range(0, 14)];
        end
        return op;
    endfunction

    // Called just after a falling edge; leaves just after the next one
    task automatic step(input logic [2:0] es, input logic er,
                        input logic ir, input logic dr,
                        input logic [5:0] op);
        opcode     = op;
        imem_ready = ir;
        dmem_ready = dr;
        #1;
        check("state", state, es);
        check("retire", instr_retire, er);
        check("halted", halted, m_halt);
        check("cycle_cnt", cycle_cnt, m_cyc);
        check("instr_cnt", instr_cnt, m_ins);
        @(posedge CLK);
        if (!m_halt)
            m_cyc = m_cyc + 1'b1;
        if (er)
            m_ins = m_ins + 1'b1;
        @(negedge CLK);
    endtask

    task automatic run_instr(input logic [5:0] op, input int ifw,
                             input int memw);
        int k;
        k = kind_of(op);
        for (int i = 0; i < ifw; i++)
            step(C_IF, 1'b0, 1'b0, 1'($urandom), rand_op());
        step(C_IF, 1'b0, 1'b1, 1'($urandom), rand_op());
        step(C_ID, 1'(k == K_JUMP), 1'($urandom), 1'($urandom), op);
        if (k == K_HALT)
            m_halt = 1'b1;
        if (k == K_BEQ)
            step(C_BEXE, 1'b1, 1'($urandom), 1'($urandom), op);
        if (k == K_ALU) begin
            step(C_AEXE, 1'b0, 1'($urandom), 1'($urandom), op);
            step(C_AWB, 1'b1, 1'($urandom), 1'($urandom), op);
        end
        if (k == K_SW || k == K_LW) begin
            step(C_CEXE, 1'b0, 1'($urandom), 1'($urandom), op);
            for (int i = 0; i < memw; i++)
                step(C_MEM, 1'b0, 1'($urandom), 1'b0, op);
            step(C_MEM, 1'(k == K_SW), 1'($urandom), 1'b1, op);
            if (k == K_LW)
                step(C_CWB, 1'b1, 1'($urandom), 1'($urandom), op);
        end
    endtask

    // Asynchronous reset applied between edges, checked before any edge
    task automatic async_reset();
        #2;
        Reset = 1'b1;
        #1;
        check("rst_state", state, C_IF);
        check("rst_halted", halted, 1'b0);
        check("rst_cycle", cycle_cnt, 0);
        check("rst_instr", instr_cnt, 0);
        check("rst_retire", instr_retire, 1'b0);
        m_cyc  = '0;
        m_ins  = '0;
        m_halt = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    initial begin
        Reset      = 1'b1;
        opcode     = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        m_cyc      = '0;
        m_ins      = '0;
        m_halt     = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;

        run_instr(6'b000000, 0, 0);
        async_reset();
        run_instr(6'b110001, 0, 3);
        step(C_IF, 1'b0, 1'b0, 1'b1, 6'b111111);
        async_reset();

        run_instr(6'b110100, 0, 0);
        run_instr(6'b110000, 0, 0);
        run_instr(6'b111000, 0, 0);
        run_instr(6'b000010, 2, 0);

        // Reset while stalled in MEM must discard the partial lw
        opcode     = 6'b110001;
        imem_ready = 1'b1;
        step(C_IF, 1'b0, 1'b1, 1'b0, 6'b110001);
        step(C_ID, 1'b0, 1'b0, 1'b0, 6'b110001);
        step(C_CEXE, 1'b0, 1'b0, 1'b0, 6'b110001);
        step(C_MEM, 1'b0, 1'b1, 1'b0, 6'b110001);
        dmem_ready = 1'b0;
        async_reset();
        run_instr(6'b000001, 2, 0);

        for (int n = 0; n < 80; n++)
            run_instr(rand_op(), $urandom_range(0, 2),
                      $urandom_range(0, 3));

        run_instr(6'b111111, $urandom_range(0, 2), 0);
        for (int n = 0; n < 100; n++)
            step(C_IF, 1'b0, 1'($urandom), 1'($urandom), rand_op());
        async_reset();
        run_instr(6'b111010, 0, 0);
        run_instr(6'b110001, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
